// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier -- iterative 32x32 shift-add multiplier (multi-cycle MUL unit)
//
// Accumulates one partial product per clock through a single ripple-carry
// adder (fulladderN, declared below) and returns a 64-bit product through a
// start/done handshake.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   request; sampled only while idle
//   is_signed  in   1   two's complement operands (used only with MUL_SIGNED_EN)
//   a          in  32   multiplicand, sampled with start
//   b          in  32   multiplier, sampled with start
//   busy       out  1   operation in progress
//   done       out  1   one-cycle pulse, product valid
//   product    out 64   result, held until the next accepted start
//
// Configuration macro: MUL_SIGNED_EN
//   defined   : signed operands are multiplied as magnitudes, and a negative
//               result is negated in two extra cycles (FIX_LO, FIX_HI).
//   undefined : unsigned only, is_signed ignored, latency always 32 cycles.
// ---------------------------------------------------------------------------

// N-bit ripple-carry adder shared by every addition in the multiplier.
module fulladderN #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[N];
endmodule

module seq_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

`ifdef MUL_SIGNED_EN
  typedef enum logic [1:0] {IDLE, ITER, FIX_LO, FIX_HI} state_t;
`else
  typedef enum logic [1:0] {IDLE, ITER} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mcand_q, mcand_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [63:0] product_q, product_d;
`ifdef MUL_SIGNED_EN
  logic        cy_q, cy_d;
`endif

  // Operand values captured on an accepted start.
  logic [31:0] a_cap, b_cap;
  logic        neg_cap;

  // Shared adder.
  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  fulladderN #(.N(32)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef MUL_SIGNED_EN
  // Two's negate without an adder: bits up to and including the lowest set
  // bit pass through, every bit above it is inverted. Keeps the shared adder
  // free during capture.
  function automatic logic [31:0] negate(input logic [31:0] x);
    logic seen;
    negate = '0;
    seen   = 1'b0;
    for (int i = 0; i < 32; i++) begin
      negate[i] = x[i] ^ seen;
      seen      = seen | x[i];
    end
  endfunction

  assign a_cap   = (is_signed && a[31]) ? negate(a) : a;
  assign b_cap   = (is_signed && b[31]) ? negate(b) : b;
  assign neg_cap = is_signed & (a[31] ^ b[31]);
`else
  logic unused_cfg;
  assign a_cap      = a;
  assign b_cap      = b;
  assign neg_cap    = 1'b0;
  assign unused_cfg = is_signed ^ neg_q;
`endif

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
`ifdef MUL_SIGNED_EN
    cy_d      = cy_q;
`endif
    add_a     = hi_q;
    add_b     = mcand_q;
    add_cin   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          hi_d    = '0;
          lo_d    = b_cap;
          mcand_d = a_cap;
          cnt_d   = '0;
          neg_d   = neg_cap;
          busy_d  = 1'b1;
          state_d = ITER;
        end
      end

      ITER: begin
        // Shift right by one; the adder carry-out becomes the new top bit
        // and the bit leaving hi moves into the vacated top of lo.
        if (lo_q[0]) begin
          {hi_d, lo_d} = {add_cout, add_sum, lo_q[31:1]};
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[31:1]};
        end

        if (cnt_q == 5'd31) begin
`ifdef MUL_SIGNED_EN
          if (neg_q) begin
            state_d = FIX_LO;
          end else begin
            state_d   = IDLE;
            product_d = {hi_d, lo_d};
            done_d    = 1'b1;
            busy_d    = 1'b0;
          end
`else
          state_d   = IDLE;
          product_d = {hi_d, lo_d};
          done_d    = 1'b1;
          busy_d    = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

`ifdef MUL_SIGNED_EN
      // 64-bit negate split over two passes: ~lo + 1, then ~hi + carry.
      FIX_LO: begin
        add_a   = ~lo_q;
        add_b   = '0;
        add_cin = 1'b1;
        lo_d    = add_sum;
        cy_d    = add_cout;
        state_d = FIX_HI;
      end

      FIX_HI: begin
        add_a     = ~hi_q;
        add_b     = '0;
        add_cin   = cy_q;
        hi_d      = add_sum;
        product_d = {add_sum, lo_q};
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
`endif

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
`ifdef MUL_SIGNED_EN
      cy_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
`ifdef MUL_SIGNED_EN
      cy_q      <= cy_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
